// File: rtl/baser_257b_transcoder_if.sv
// Block-stream interface for the 257b transcoder: 66b blocks in, 257b transcoded blocks out.
// The master modport belongs to the PCS encoder side; the slave modport belongs to the transcoder.
interface baser_257b_transcoder_if #(
    parameter int FRAME_WIDTH = 66,
    parameter int TC_WIDTH    = 257
);
    logic                   i_valid;
    logic [FRAME_WIDTH-1:0] i_tx_coded;
    logic                   o_valid;
    logic [TC_WIDTH-1:0]    o_tx_xcoded;

    modport master (
        output i_valid,
        output i_tx_coded,
        input  o_valid,
        input  o_tx_xcoded
    );

    modport slave (
        input  i_valid,
        input  i_tx_coded,
        output o_valid,
        output o_tx_xcoded
    );
endinterface

// File: rtl/baser_257b_transcoder.sv
// Transmit-side 64b/66b to 256b/257b transcoder with block, control and invalid-group statistics.
// Four accepted 66b blocks are folded into one 257b block that is registered on the following edge.
module baser_257b_transcoder #(
    parameter int DATA_WIDTH        = 64,
    parameter int HDR_WIDTH         = 2,
    parameter int FRAME_WIDTH       = DATA_WIDTH + HDR_WIDTH,
    parameter int TRANSCODER_BLOCKS = 4,
    parameter int TC_WIDTH          = TRANSCODER_BLOCKS * DATA_WIDTH + 1,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       i_rst,
    baser_257b_transcoder_if.slave     bus,
    output logic [COUNT_WIDTH-1:0]     o_block_count,
    output logic [COUNT_WIDTH-1:0]     o_ctrl_count,
    output logic [COUNT_WIDTH-1:0]     o_inv_count
);
    localparam int CAT_WIDTH = TRANSCODER_BLOCKS * DATA_WIDTH;

    logic [1:0]             idx_q, idx_d;
    logic [FRAME_WIDTH-1:0] slot_q [TRANSCODER_BLOCKS-1];
    logic [FRAME_WIDTH-1:0] slot_d [TRANSCODER_BLOCKS-1];
    logic [TC_WIDTH-1:0]    xcoded_q, xcoded_d;
    logic                   valid_q, valid_d;
    logic [COUNT_WIDTH-1:0] block_count_q, block_count_d;
    logic [COUNT_WIDTH-1:0] ctrl_count_q, ctrl_count_d;
    logic [COUNT_WIDTH-1:0] inv_count_q, inv_count_d;

    logic [FRAME_WIDTH-1:0]       frames [TRANSCODER_BLOCKS];
    logic [CAT_WIDTH-1:0]         data_cat;
    logic [TC_WIDTH-1:0]          ctrl_packed;
    logic [TC_WIDTH-1:0]          built;
    logic [TRANSCODER_BLOCKS-1:0] data_flags;
    logic                         any_ctrl;
    logic                         any_inv;
    logic                         first_seen;
    logic [8:0]                   pos;
    logic [HDR_WIDTH-1:0]         hdr;

    // Slot 3 is never stored: the group is built from the three captured slots plus the live input.
    always_comb begin
        data_cat    = '0;
        ctrl_packed = '0;
        data_flags  = '0;
        any_ctrl    = 1'b0;
        any_inv     = 1'b0;
        first_seen  = 1'b0;
        pos         = 9'd5;
        hdr         = '0;
        built       = '0;
        for (int k = 0; k < TRANSCODER_BLOCKS - 1; k++) begin
            frames[k] = slot_q[k];
        end
        frames[TRANSCODER_BLOCKS-1] = bus.i_tx_coded;

        for (int k = 0; k < TRANSCODER_BLOCKS; k++) begin
            hdr = frames[k][FRAME_WIDTH-1 -: HDR_WIDTH];
            data_flags[k] = (hdr == 2'b01);
            if (hdr == 2'b10) begin
                any_ctrl = 1'b1;
            end else if (hdr != 2'b01) begin
                any_inv = 1'b1;
            end
            data_cat[k*DATA_WIDTH +: DATA_WIDTH] = frames[k][DATA_WIDTH-1:0];
        end

        // The first control block drops payload[7:4]; its type nibble stays lowest in its 60-bit field.
        for (int k = 0; k < TRANSCODER_BLOCKS; k++) begin
            if (!first_seen && frames[k][FRAME_WIDTH-1 -: HDR_WIDTH] == 2'b10) begin
                ctrl_packed = ctrl_packed |
                    (TC_WIDTH'({frames[k][DATA_WIDTH-1:8], frames[k][3:0]}) << pos);
                pos        = pos + 9'd60;
                first_seen = 1'b1;
            end else begin
                ctrl_packed = ctrl_packed | (TC_WIDTH'(frames[k][DATA_WIDTH-1:0]) << pos);
                pos         = pos + 9'd64;
            end
        end

        if (any_inv) begin
            built = {data_cat[CAT_WIDTH-5:0], 4'b1111, 1'b0};
        end else if (any_ctrl) begin
            built      = ctrl_packed;
            built[4:1] = data_flags;
            built[0]   = 1'b0;
        end else begin
            built = {data_cat, 1'b1};
        end
    end

    always_comb begin
        idx_d         = idx_q;
        slot_d        = slot_q;
        xcoded_d      = xcoded_q;
        valid_d       = 1'b0;
        block_count_d = block_count_q;
        ctrl_count_d  = ctrl_count_q;
        inv_count_d   = inv_count_q;
        if (bus.i_valid) begin
            idx_d = idx_q + 2'd1;
            if (idx_q != 2'd3) begin
                slot_d[idx_q] = bus.i_tx_coded;
            end else begin
                valid_d       = 1'b1;
                xcoded_d      = built;
                block_count_d = block_count_q + COUNT_WIDTH'(1);
                if (any_inv) begin
                    inv_count_d = inv_count_q + COUNT_WIDTH'(1);
                end else if (any_ctrl) begin
                    ctrl_count_d = ctrl_count_q + COUNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            idx_q         <= '0;
            for (int k = 0; k < TRANSCODER_BLOCKS - 1; k++) begin
                slot_q[k] <= '0;
            end
            xcoded_q      <= '0;
            valid_q       <= 1'b0;
            block_count_q <= '0;
            ctrl_count_q  <= '0;
            inv_count_q   <= '0;
        end else begin
            idx_q         <= idx_d;
            slot_q        <= slot_d;
            xcoded_q      <= xcoded_d;
            valid_q       <= valid_d;
            block_count_q <= block_count_d;
            ctrl_count_q  <= ctrl_count_d;
            inv_count_q   <= inv_count_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_tx_xcoded = xcoded_q;
    assign o_block_count   = block_count_q;
    assign o_ctrl_count    = ctrl_count_q;
    assign o_inv_count     = inv_count_q;
endmodule

// File: tb/tb_baser_257b_transcoder.sv
// Scoreboard bench for the 257b transcoder: stimulus pushes expected blocks and counters,
// a negedge monitor pops and compares on every output strobe.
module tb_baser_257b_transcoder;
    typedef struct {
        logic [256:0] x;
        logic [31:0]  blocks;
        logic [31:0]  ctrls;
        logic [31:0]  invs;
    } exp_t;

    logic        clk;
    logic        i_rst;
    logic [31:0] o_block_count;
    logic [31:0] o_ctrl_count;
    logic [31:0] o_inv_count;

    exp_t        exp_q[$];
    int          errors;
    int          checks;
    int          cycle;
    int          last_strobe;
    int          burst_strobes;
    bit          burst_mode;
    logic [31:0] exp_blocks;
    logic [31:0] exp_ctrls;
    logic [31:0] exp_invs;

    baser_257b_transcoder_if bus ();

    baser_257b_transcoder dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .bus          (bus),
        .o_block_count(o_block_count),
        .o_ctrl_count (o_ctrl_count),
        .o_inv_count  (o_inv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [256:0] act, input logic [256:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_expect(input logic [256:0] x, input bit is_ctrl, input bit is_inv);
        exp_t e;
        exp_blocks++;
        if (is_inv) exp_invs++;
        else if (is_ctrl) exp_ctrls++;
        e.x      = x;
        e.blocks = exp_blocks;
        e.ctrls  = exp_ctrls;
        e.invs   = exp_invs;
        exp_q.push_back(e);
    endtask

    task automatic send_block(input logic [1:0] hdr, input logic [63:0] payload);
        bus.i_valid    = 1'b1;
        bus.i_tx_coded = {hdr, payload};
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        idle(n);
        i_rst = 1'b0;
        exp_blocks = '0;
        exp_ctrls  = '0;
        exp_invs   = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " o_valid"}, 257'(bus.o_valid), 257'(0));
        check({tag, " o_tx_xcoded"}, bus.o_tx_xcoded, 257'(0));
        check({tag, " o_block_count"}, 257'(o_block_count), 257'(0));
        check({tag, " o_ctrl_count"}, 257'(o_ctrl_count), 257'(0));
        check({tag, " o_inv_count"}, 257'(o_inv_count), 257'(0));
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 40;
        while (exp_q.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s drain: %0d outputs still pending, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Independent bit-serial reference used for the random burst.
    function automatic logic [256:0] model(input logic [3:0][65:0] b, output bit is_ctrl,
                                           output bit is_inv);
        logic [256:0] r;
        logic [255:0] cat;
        int           p;
        bit           first;
        r = '0;
        is_ctrl = 0;
        is_inv = 0;
        for (int k = 0; k < 4; k++) begin
            if (b[k][65:64] == 2'b10) is_ctrl = 1;
            else if (b[k][65:64] != 2'b01) is_inv = 1;
            for (int i = 0; i < 64; i++) cat[64*k+i] = b[k][i];
        end
        if (is_inv) begin
            r[4:1] = 4'b1111;
            for (int i = 0; i < 252; i++) r[5+i] = cat[i];
        end else if (!is_ctrl) begin
            r[0] = 1'b1;
            for (int i = 0; i < 256; i++) r[1+i] = cat[i];
        end else begin
            for (int k = 0; k < 4; k++) r[1+k] = (b[k][65:64] == 2'b01);
            p = 5;
            first = 1;
            for (int k = 0; k < 4; k++) begin
                if (first && b[k][65:64] == 2'b10) begin
                    first = 0;
                    for (int i = 0; i < 4; i++) begin r[p] = b[k][i]; p++; end
                    for (int i = 8; i < 64; i++) begin r[p] = b[k][i]; p++; end
                end else begin
                    for (int i = 0; i < 64; i++) begin r[p] = b[k][i]; p++; end
                end
            end
        end
        return r;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected strobe at cycle %0d: o_valid=1 expected 0", cycle);
                end else begin
                    e = exp_q.pop_front();
                    check("o_tx_xcoded", bus.o_tx_xcoded, e.x);
                    check("o_block_count", 257'(o_block_count), 257'(e.blocks));
                    check("o_ctrl_count", 257'(o_ctrl_count), 257'(e.ctrls));
                    check("o_inv_count", 257'(o_inv_count), 257'(e.invs));
                end
                if (burst_mode) begin
                    if (last_strobe >= 0) begin
                        check("strobe spacing", 257'(cycle - last_strobe), 257'(4));
                    end
                    last_strobe = cycle;
                    burst_strobes++;
                end
            end
        end
    end

    initial begin
        logic [3:0][65:0] blk;
        logic [256:0]     x;
        bit               c;
        bit               v;
        errors         = 0;
        checks         = 0;
        burst_mode     = 0;
        last_strobe    = -1;
        burst_strobes  = 0;
        bus.i_valid    = 1'b0;
        bus.i_tx_coded = '0;
        exp_blocks     = '0;
        exp_ctrls      = '0;
        exp_invs       = '0;
        i_rst          = 1'b1;
        @(posedge clk);
        #1;
        do_reset(10);
        check_all_zero("reset");

        // All-data group
        push_expect({{64{4'hA}}, 1'b1}, 0, 0);
        repeat (4) send_block(2'b01, 64'hAAAA_AAAA_AAAA_AAAA);
        idle(2);

        // Control in block 0
        push_expect({{48{4'hA}}, 56'h0, 4'hE, 4'b1110, 1'b0}, 1, 0);
        send_block(2'b10, 64'h0000_0000_0000_001E);
        repeat (3) send_block(2'b01, 64'hAAAA_AAAA_AAAA_AAAA);
        idle(2);

        // Control in block 2, back-to-back with the next group
        push_expect({{16{4'hF}}, 56'h07070707070707, 4'hD, {32{4'hF}}, 4'b1011, 1'b0}, 1, 0);
        send_block(2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        send_block(2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        send_block(2'b10, 64'h0707_0707_0707_07FD);
        send_block(2'b01, 64'hFFFF_FFFF_FFFF_FFFF);

        // Invalid header in block 1
        push_expect({{63{4'hA}}, 4'b1111, 1'b0}, 0, 1);
        send_block(2'b01, 64'hAAAA_AAAA_AAAA_AAAA);
        send_block(2'b11, 64'hAAAA_AAAA_AAAA_AAAA);
        send_block(2'b01, 64'hAAAA_AAAA_AAAA_AAAA);
        send_block(2'b01, 64'hAAAA_AAAA_AAAA_AAAA);
        idle(2);

        // Gapped valid pattern 1,0,1,0,0,1,1
        push_expect({64'h4, 64'h3, 64'h2, 64'h1, 1'b1}, 0, 0);
        send_block(2'b01, 64'h1);
        idle(1);
        send_block(2'b01, 64'h2);
        idle(2);
        send_block(2'b01, 64'h3);
        send_block(2'b01, 64'h4);
        idle(4);
        drain("directed");

        // Reset after two accepted blocks discards them
        send_block(2'b01, 64'h5);
        send_block(2'b01, 64'h6);
        do_reset(1);
        check_all_zero("mid-group reset");
        push_expect({64'h44, 64'h33, 64'h22, 64'h11, 1'b1}, 0, 0);
        send_block(2'b01, 64'h11);
        send_block(2'b01, 64'h22);
        send_block(2'b01, 64'h33);
        send_block(2'b01, 64'h44);
        idle(4);
        drain("post-reset");

        // 1000 back-to-back groups with random data/control headers
        do_reset(2);
        last_strobe = -1;
        burst_mode  = 1;
        for (int g = 0; g < 1000; g++) begin
            for (int k = 0; k < 4; k++) begin
                blk[k] = {($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, $urandom(), $urandom()};
            end
            x = model(blk, c, v);
            push_expect(x, c, v);
            for (int k = 0; k < 4; k++) send_block(blk[k][65:64], blk[k][63:0]);
        end
        idle(3);
        drain("burst");
        burst_mode = 0;
        check("burst strobes", 257'(burst_strobes), 257'(1000));
        check("burst o_block_count", 257'(o_block_count), 257'(1000));
        check("burst o_inv_count", 257'(o_inv_count), 257'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/baser_257b_transcoder.md
Name: baser_257b_transcoder

Overview:
Transmit-side 64b/66b-to-256b/257b transcoder. It collects four consecutive 66b blocks from the PCS encoder path and emits one 257b transcoded block. The output feeds the scrambler and the 257b checker used in the BASE-R verification environment. It also keeps block, control and invalid-block statistics, which the benches compare directly against the receive-side checker counters.

Parameters:
DATA_WIDTH, 64, payload bits per 66b block
HDR_WIDTH, 2, sync header bits per 66b block
FRAME_WIDTH, DATA_WIDTH+HDR_WIDTH (66), 66b block width
TRANSCODER_BLOCKS, 4, 66b blocks per transcoded block
TC_WIDTH, TRANSCODER_BLOCKS*DATA_WIDTH+1 (257), transcoded block width
COUNT_WIDTH, 32, statistics counter width

Ports:
clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  i_tx_coded carries a block this cycle
i_tx_coded  in  FRAME_WIDTH  66b block; sync header [65:64], payload [63:0], block type byte at payload [7:0]
o_tx_xcoded  out  TC_WIDTH  257b transcoded block
o_valid  out  1  one-cycle strobe, o_tx_xcoded valid
o_block_count  out  COUNT_WIDTH  257b blocks emitted
o_ctrl_count  out  COUNT_WIDTH  emitted blocks containing at least one control 66b block
o_inv_count  out  COUNT_WIDTH  emitted blocks containing an invalid sync header

Behaviour:
- Reset: all outputs are 0, the block index is 0, and the capture buffer is cleared. Reset takes priority over i_valid in the same cycle. Reset during a partial group discards the captured blocks; no output is produced for them.
- Capture: a 2-bit index selects slot 0..3. Each cycle with i_valid=1 stores i_tx_coded in the slot and increments the index. Cycles with i_valid=0 hold the index and buffer, so gaps inside a group are allowed.
- Emission: when slot 3 is written, the block is built from slots 0..2 plus the live slot-3 input. It is registered into o_tx_xcoded with o_valid=1 on the next edge, giving a latency of 1 cycle after the 4th accepted block.
- o_valid is 0 in every other cycle. o_tx_xcoded holds its last value between strobes. The index wraps 3→0, so back-to-back groups need no idle cycle.
- Sync header classification: 2'b01 is data, 2'b10 is control, 2'b00 or 2'b11 is invalid.
- All-data group:
  - bit0 = 1.
  - Payload of block k is placed at [64k+64 : 64k+1].
- Group with any control block and no invalid headers:
  - bit0 = 0.
  - bits[4:1] = per-block flag, block k at bit k+1: 1 for data, 0 for control.
  - From bit 5 upward, blocks 0..3 are packed in order.
  - The first control block contributes 60 bits: {payload[63:8], payload[3:0]}. Its type nibble payload[3:0] sits lowest, and payload[7:4] is dropped.
  - Every other block contributes its full 64-bit payload.
  - Total width is 1 + 4 + 60 + 192 = 257.
- Group with any invalid header:
  - Emit bit0 = 0, bits[4:1] = 4'b1111 (data flags set but header says control). The receiving checker counts this as invalid.
  - bits[256:5] are packed as in the all-data layout shifted by 4, with payload bits truncated to fit.
- Counters update in the same edge as o_valid:
  - o_block_count +1 on every emitted block.
  - o_ctrl_count +1 when bit0 = 0 and the group was valid.
  - o_inv_count +1 for an invalid group.
  - Counters wrap modulo 2^COUNT_WIDTH.
- The block is fully pipelined: one 257b output per four accepted inputs, with no backpressure.

Test Plan:
- Reset 10 cycles, then 4 consecutive valid blocks of {2'b01, 64'hAAAAAAAAAAAAAAAA} → o_valid one cycle after the 4th block. o_tx_xcoded = {256'hAAAA…AA, 1'b1}; o_block_count = 1, o_ctrl_count = 0, o_inv_count = 0.
- Block0 = {2'b10, 64'h000000000000001E} followed by 3 data blocks of 64'hAAAA… → bit0 = 0, bits[4:1] = 4'b1110, bits[8:5] = 4'hE, bits[64:9] = 0, bits[256:65] = all A's; o_ctrl_count = 1.
- Block2 = {2'b10, 64'h07070707070707FD}, blocks 0, 1, 3 are data 64'hFFFF… → bits[4:1] = 4'b1011. The first control block's 60 bits {56'h07070707070707, 4'hD} are placed after two full data payloads.
- Block1 header 2'b11 → bit0 = 0, bits[4:1] = 4'b1111; o_inv_count = 1, o_block_count increments.
- Valid pattern 1,0,1,0,0,1,1: o_valid fires exactly once, after the 4th accepted block. Also assert i_rst after 2 accepted blocks: all outputs go to 0, and the next 4 valid blocks produce exactly one aligned output.
- 1000 back-to-back groups of random valid headers → 1000 strobes spaced exactly 4 cycles apart; o_block_count = 1000, and a loopback into the receive checker reports 0 invalid blocks.
